// File: rtl/toy_fetch_realign_buf.sv
// -----------------------------------------------------------------------------
// toy_fetch_realign_buf
//
// Instruction realignment buffer. 32-bit memory words are stored in a circular
// word array. The read side walks the same array in half-word steps and
// presents one instruction per handshake:
//   - a 16-bit compressed instruction, zero-extended, or
//   - a full 32-bit instruction, which may straddle two word slots.
//
// The write pointer counts words and the read pointer counts half-words. Both
// carry one extra wrap bit, so the fill level is a plain modular subtraction.
//
// A redirect (clear) empties the buffer. When the redirect target is half-word
// aligned (PC[1]=1), the lower half of the first word after the flush is
// skipped by starting the read pointer at half 1.
// -----------------------------------------------------------------------------
module toy_fetch_realign_buf #(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          clear_mis_align,
    input  logic          req_vld,
    output logic          req_rdy,
    input  logic [31:0]   req_pld,
    output logic          ack_vld,
    input  logic          ack_rdy,
    output logic [31:0]   ack_pld,
    output logic          ack_is_rvc,
    output logic [AW:0]   word_cnt
);

    // Sized constants keep every pointer operation at its own width.
    localparam logic [AW:0]   WPTR_ONE = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] HALF_ONE = (AW+2)'(1);
    localparam logic [AW+1:0] HALF_TWO = (AW+2)'(2);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Select a half-word of a little-endian word: 0 -> bits[15:0], 1 -> [31:16].
    function automatic logic [15:0] half_of(input logic [31:0] word,
                                            input logic        sel);
        return sel ? word[31:16] : word[15:0];
    endfunction

    // A half-word starts a compressed instruction unless its low two bits are 11.
    function automatic logic is_compressed(input logic [15:0] half);
        return (half[1:0] != 2'b11);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH];

    logic [AW:0]   wptr_q, wptr_d;          // word units, one wrap bit
    logic [AW+1:0] rptr_q, rptr_d;          // half-word units, one wrap bit
    logic          pending_skip_q, pending_skip_d;

    // -------------------------------------------------------------------------
    // Derived occupancy
    // -------------------------------------------------------------------------
    logic [AW+1:0] half_avail;
    logic [AW:0]   words_held;

    // Both subtractions rely on natural wrap of the full pointer widths.
    always_comb begin
        words_held = wptr_q - rptr_q[AW+1:1];
        half_avail = {wptr_q, 1'b0} - rptr_q;
    end

    assign word_cnt = words_held;

    // -------------------------------------------------------------------------
    // Head decode
    // -------------------------------------------------------------------------
    logic [AW+1:0] rptr_nxt_half;
    logic [15:0]   head_h0;
    logic [15:0]   head_h1;
    logic          head_rvc;
    logic          head_vld;

    // Read the two half-words at the head; the second may sit in the next
    // slot, and its slot index wraps with the pointer.
    always_comb begin
        rptr_nxt_half = rptr_q + HALF_ONE;
        head_h0       = half_of(mem_q[rptr_q[AW:1]],        rptr_q[0]);
        head_h1       = half_of(mem_q[rptr_nxt_half[AW:1]], rptr_nxt_half[0]);
        head_rvc      = is_compressed(head_h0);
        head_vld      = (half_avail != '0) &&
                        (head_rvc || (half_avail >= HALF_TWO));
    end

    // Present the head instruction; payload is forced to zero while nothing is
    // valid so that unwritten storage never leaks onto the port.
    always_comb begin
        ack_vld    = head_vld;
        ack_is_rvc = head_vld && head_rvc;
        ack_pld    = '0;
        if (head_vld) begin
            ack_pld = head_rvc ? {16'h0000, head_h0} : {head_h1, head_h0};
        end
    end

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic push;
    logic pop;

    // Ready comes only from registered state and clear, so a full buffer does
    // not accept a word even if a pop happens in the same cycle.
    always_comb begin
        req_rdy = (words_held != FULL_CNT) && !clear;
        push    = req_vld && req_rdy;
        pop     = head_vld && ack_rdy && !clear;
    end

    // -------------------------------------------------------------------------
    // Pointer next-state
    // -------------------------------------------------------------------------

    // Clear dominates; otherwise push and pop apply independently. The first
    // word after a misaligned redirect lands in slot 0 and the read pointer
    // jumps over its lower half.
    always_comb begin
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        pending_skip_d = pending_skip_q;

        if (clear) begin
            wptr_d         = '0;
            rptr_d         = '0;
            pending_skip_d = clear_mis_align;
        end else begin
            if (push) begin
                wptr_d = wptr_q + WPTR_ONE;
            end
            if (pop) begin
                rptr_d = rptr_q + (head_rvc ? HALF_ONE : HALF_TWO);
            end
            if (push && pending_skip_q) begin
                rptr_d         = HALF_ONE;
                pending_skip_d = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------

    // Control state: asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            pending_skip_q <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            pending_skip_q <= pending_skip_d;
        end
    end

    // Word storage: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= req_pld;
        end
    end

endmodule

// File: tb/tb_toy_fetch_realign_buf.sv
// -----------------------------------------------------------------------------
// Testbench for toy_fetch_realign_buf.
// A half-word queue reference model turns accepted words into the expected
// instruction stream; the monitor pops and compares on every ack handshake.
// -----------------------------------------------------------------------------
module tb_toy_fetch_realign_buf;

    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          clear_mis_align;
    logic          req_vld;
    logic          req_rdy;
    logic [31:0]   req_pld;
    logic          ack_vld;
    logic          ack_rdy;
    logic [31:0]   ack_pld;
    logic          ack_is_rvc;
    logic [AW:0]   word_cnt;

    toy_fetch_realign_buf #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .clear_mis_align (clear_mis_align),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_pld         (req_pld),
        .ack_vld         (ack_vld),
        .ack_rdy         (ack_rdy),
        .ack_pld         (ack_pld),
        .ack_is_rvc      (ack_is_rvc),
        .word_cnt        (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [15:0] hq[$];     // half-words held, in order
    logic [32:0] sb_q[$];   // expected {is_rvc, pld}
    logic        m_skip = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Turn complete instructions at the head of the half queue into expectations.
    task automatic model_decode();
        logic [15:0] h;
        while (hq.size() > 0) begin
            h = hq[0];
            if (h[1:0] != 2'b11) begin
                sb_q.push_back({1'b1, 16'h0000, h});
                void'(hq.pop_front());
            end else if (hq.size() >= 2) begin
                sb_q.push_back({1'b0, hq[1], h});
                void'(hq.pop_front());
                void'(hq.pop_front());
            end else begin
                break;
            end
        end
    endtask

    task automatic model_push(input logic [31:0] w);
        if (m_skip) begin
            hq.push_back(w[31:16]);
            m_skip = 1'b0;
        end else begin
            hq.push_back(w[15:0]);
            hq.push_back(w[31:16]);
        end
        model_decode();
    endtask

    task automatic model_clear(input logic mis);
        hq.delete();
        sb_q.delete();
        m_skip = mis;
    endtask

    // Drive one word; returns #1 after the accepting edge.
    task automatic push_word(input logic [31:0] w);
        int n;
        n = 0;
        req_vld = 1'b1;
        req_pld = w;
        @(negedge clk);
        while (!req_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) begin
            chk("push_timeout", {31'b0, req_rdy}, 32'd1);
            req_vld = 1'b0;
            return;
        end
        @(posedge clk);
        model_push(w);
        #1 req_vld = 1'b0;
    endtask

    // Exactly one ack handshake.
    task automatic pop_one();
        int n;
        n = 0;
        while (!ack_vld && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (!ack_vld) begin
            chk("pop_timeout", {31'b0, ack_vld}, 32'd1);
            return;
        end
        ack_rdy = 1'b1;
        @(posedge clk);
        #1 ack_rdy = 1'b0;
    endtask

    task automatic do_clear(input logic mis);
        clear           = 1'b1;
        clear_mis_align = mis;
        @(posedge clk);
        #1;
        clear           = 1'b0;
        clear_mis_align = 1'b0;
        model_clear(mis);
    endtask

    task automatic drain();
        int n;
        n = 0;
        ack_rdy = 1'b1;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled on the falling edge ahead of the handshake edge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && ack_vld && ack_rdy && !clear) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("ack_pld", ack_pld, e[31:0]);
                chk("ack_is_rvc", {31'b0, ack_is_rvc}, {31'b0, e[32]});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; clear = 1'b0; clear_mis_align = 1'b0;
        req_vld = 1'b0; req_pld = '0; ack_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_req_rdy", {31'b0, req_rdy}, 32'd1);
        chk("rst_ack_vld", {31'b0, ack_vld}, 32'd0);
        chk("rst_ack_pld", ack_pld, 32'd0);
        chk("rst_ack_rvc", {31'b0, ack_is_rvc}, 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);

        // Aligned 32-bit stream
        ack_rdy = 1'b1;
        push_word(32'h0000_0013);
        chk("aln_first_vld", {31'b0, ack_vld}, 32'd1);
        push_word(32'h0010_0093);
        push_word(32'h0020_0113);
        drain();
        chk("aln_cnt0", 32'(word_cnt), 32'd0);

        // Compressed / full mix
        push_word(32'h0013_0001);
        push_word(32'h4505_0513);
        drain();
        chk("mix_cnt0", 32'(word_cnt), 32'd0);

        // Straddle stall
        push_word(32'h0513_0001);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_vld", {31'b0, ack_vld}, 32'd0);
        end
        @(posedge clk);
        #1;
        push_word(32'h0000_0051);
        chk("strad_pld", ack_pld, 32'h0051_0513);
        chk("strad_rvc", {31'b0, ack_is_rvc}, 32'd0);
        drain();
        chk("strad_cnt0", 32'(word_cnt), 32'd0);

        // Misaligned redirect
        do_clear(1'b1);
        push_word(32'h8082_0001);
        chk("mis_pld", ack_pld, 32'h0000_8082);
        chk("mis_rvc", {31'b0, ack_is_rvc}, 32'd1);
        drain();
        chk("mis_cnt0", 32'(word_cnt), 32'd0);

        // Full, backpressure and wrap with a slot 31 -> slot 0 straddle
        ack_rdy = 1'b0;
        do_clear(1'b0);
        w = $urandom;
        push_word({w[31:18], 2'b11, 16'h0001});
        for (int i = 1; i < DEPTH; i++) begin
            w = $urandom;
            push_word({w[31:18], 2'b11, w[15:0]});
        end
        chk("full_req_rdy", {31'b0, req_rdy}, 32'd0);
        chk("full_cnt", 32'(word_cnt), 32'(DEPTH));
        req_vld = 1'b1;
        req_pld = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1 req_vld = 1'b0;
        chk("full_reject_cnt", 32'(word_cnt), 32'(DEPTH));
        pop_one();
        chk("half_pop_rdy", {31'b0, req_rdy}, 32'd0);
        chk("half_pop_cnt", 32'(word_cnt), 32'(DEPTH));
        pop_one();
        chk("free_rdy", {31'b0, req_rdy}, 32'd1);
        chk("free_cnt", 32'(word_cnt), 32'(DEPTH - 1));
        ack_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            push_word(w);
        end
        drain();

        // Clear colliding with push and pop
        ack_rdy = 1'b0;
        do_clear(1'b0);
        push_word(32'h0000_0013);
        push_word(32'h0010_0093);
        @(posedge clk);
        #1;
        clear   = 1'b1;
        req_vld = 1'b1;
        req_pld = 32'hDEAD_BEEF;
        ack_rdy = 1'b1;
        @(negedge clk);
        chk("clr_cycle_vld", {31'b0, ack_vld}, 32'd1);
        @(posedge clk);
        #1;
        clear   = 1'b0;
        req_vld = 1'b0;
        ack_rdy = 1'b0;
        model_clear(1'b0);
        chk("clr_cnt", 32'(word_cnt), 32'd0);
        chk("clr_vld", {31'b0, ack_vld}, 32'd0);
        ack_rdy = 1'b1;
        push_word(32'h0030_0193);
        drain();

        // Asynchronous reset mid-stream
        ack_rdy = 1'b0;
        push_word(32'h0040_0213);
        push_word(32'h0050_0293);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ack_vld", {31'b0, ack_vld}, 32'd0);
        chk("arst_req_rdy", {31'b0, req_rdy}, 32'd1);
        chk("arst_cnt", 32'(word_cnt), 32'd0);
        model_clear(1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ack_rdy = 1'b1;
        push_word(32'h0060_0313);
        drain();
        chk("end_cnt0", 32'(word_cnt), 32'd0);
        chk("end_sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
